// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch: two-entry skid-buffered pipeline latch between processor stages.
//
// The main entry drives the downstream side. The skid entry catches one extra
// upstream beat when downstream stalls. in_ready is taken straight from the skid
// valid flop, so upstream never sees a combinational path from out_ready.
//
// Ports:
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-low reset
//   flush      in   synchronous squash of both entries
//   in_valid   in   upstream payload valid
//   in_ready   out  latch can accept (registered, = !skid_v)
//   in_data    in   upstream payload [WIDTH]
//   out_valid  out  main entry valid
//   out_ready  in   downstream accepts this cycle
//   out_data   out  main entry payload [WIDTH]
//   occupancy  out  number of valid entries, 0..2
//   bubble_cnt out  saturating count of downstream-ready-but-empty cycles [CNT_W]
//                   (present only when PIPE_BUBBLE_COUNT_EN is defined)
module pipe_skid_latch #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_BUBBLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  logic             r_main_v, r_skid_v;
  logic [WIDTH-1:0] r_main_d, r_skid_d;

  logic             w_main_v_nxt, w_skid_v_nxt;
  logic [WIDTH-1:0] w_main_d_nxt, w_skid_d_nxt;
  logic             w_acc_in, w_acc_out;

  assign in_ready  = ~r_skid_v;
  assign out_valid = r_main_v;
  assign out_data  = r_main_d;
  assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};

  assign w_acc_in  = in_valid & in_ready;
  assign w_acc_out = r_main_v & out_ready;

  always_comb begin
    w_main_v_nxt = r_main_v;
    w_skid_v_nxt = r_skid_v;
    w_main_d_nxt = r_main_d;
    w_skid_d_nxt = r_skid_d;
    unique case ({r_main_v, r_skid_v})
      2'b00: begin
        if (w_acc_in) begin
          w_main_d_nxt = in_data;
          w_main_v_nxt = 1'b1;
        end
      end
      2'b10: begin
        if (w_acc_out) begin
          if (w_acc_in) begin
            w_main_d_nxt = in_data;
          end else begin
            w_main_v_nxt = 1'b0;
          end
        end else if (w_acc_in) begin
          w_skid_d_nxt = in_data;
          w_skid_v_nxt = 1'b1;
        end
      end
      2'b11: begin
        // Skid always drains into main first, preserving FIFO order.
        if (w_acc_out) begin
          w_main_d_nxt = r_skid_d;
          w_skid_v_nxt = 1'b0;
        end
      end
      default: begin
        // Skid-only is unreachable; recover to EMPTY.
        w_main_v_nxt = 1'b0;
        w_skid_v_nxt = 1'b0;
      end
    endcase
    // Flush clears only the valid bits; data flops keep their contents.
    if (flush) begin
      w_main_v_nxt = 1'b0;
      w_skid_v_nxt = 1'b0;
      w_main_d_nxt = r_main_d;
      w_skid_d_nxt = r_skid_d;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else begin
      r_main_v <= w_main_v_nxt;
      r_skid_v <= w_skid_v_nxt;
      r_main_d <= w_main_d_nxt;
      r_skid_d <= w_skid_d_nxt;
    end
  end

`ifdef PIPE_BUBBLE_COUNT_EN
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_bubble_cnt <= '0;
    end else if (out_ready && !r_main_v && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`else
  // Counter width is meaningful only with the bubble counter built in.
  if (CNT_W == 0) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Scoreboard bench for pipe_skid_latch: the reference model is a plain FIFO of
// accepted payloads with capacity two. The driver pushes accepted beats, the
// monitor checks outputs each cycle and pops delivered beats.
module tb_pipe_skid_latch;
  localparam int unsigned WIDTH = 32;
`ifdef PIPE_BUBBLE_COUNT_EN
  localparam int unsigned CNT_W = 4;
`else
  localparam int unsigned CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
`ifdef PIPE_BUBBLE_COUNT_EN
  logic [CNT_W-1:0] bubble_cnt;
  int unsigned      bub_model = 0;
`endif

  pipe_skid_latch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_BUBBLE_COUNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] q[$];
  int               pre_size = 0;
  bit               mon_en = 1'b0;
  int               errors = 0;
  int               checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model FIFO, then retires the
  // beat that the coming edge delivers downstream.
  always @(negedge clk) begin
    if (mon_en && clr) begin
      pre_size = q.size();
      check("out_valid", {31'd0, out_valid}, {31'd0, pre_size > 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, pre_size < 2});
      check("occupancy", {30'd0, occupancy}, pre_size);
      if (pre_size > 0) check("out_data", out_data, q[0]);
`ifdef PIPE_BUBBLE_COUNT_EN
      check("bubble_cnt", {{(32 - CNT_W){1'b0}}, bubble_cnt}, bub_model);
      if (out_ready && pre_size == 0 && bub_model < (1 << CNT_W) - 1) bub_model++;
`endif
      if (out_ready && pre_size > 0) void'(q.pop_front());
    end
  end

  // One cycle of stimulus; acceptance is decided from the model's occupancy
  // at the start of the cycle, after the monitor has sampled it.
  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    #1;
    if (f) q.delete();
    else if (v && pre_size < 2) q.push_back(d);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    mon_en = 1'b1;

    // Streaming at full rate.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h10 + i, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure fills the skid; 0xA2 is held until in_ready returns.
    drive(1'b1, 32'hA0, 1'b0, 1'b0);
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    drive(1'b1, 32'hA2, 1'b1, 1'b0);
    drive(1'b1, 32'hA2, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while FULL with a same-cycle input beat.
    drive(1'b1, 32'hB0, 1'b0, 1'b0);
    drive(1'b1, 32'hB1, 1'b0, 1'b0);
    drive(1'b1, 32'hB2, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 19) == 0));

`ifdef PIPE_BUBBLE_COUNT_EN
    // Idle with downstream ready long enough to saturate; flush must not clear.
    repeat (20) drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("bubble_sat", {{(32 - CNT_W){1'b0}}, bubble_cnt}, (1 << CNT_W) - 1);
`endif

    // Asynchronous reset in the middle of a cycle while FULL.
    drive(1'b1, 32'hC0, 1'b0, 1'b0);
    drive(1'b1, 32'hC1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    mon_en = 1'b0;
    clr = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_occupancy", {30'd0, occupancy}, 32'd0);
    check("arst_out_data", out_data, 32'd0);
`ifdef PIPE_BUBBLE_COUNT_EN
    check("arst_bubble", {{(32 - CNT_W){1'b0}}, bubble_cnt}, 32'd0);
    bub_model = 0;
`endif
    q.delete();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    // First post-reset edge behaves as EMPTY.
    drive(1'b1, 32'hD0, 1'b1, 1'b0);
    drive(1'b1, 32'hD1, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
